morse_rx: RTL and testbench
===========================

MORSE_RX -- requirements
Module: morse_rx

Interface
REQ-001 Parameter MAX_ELEM, default 5: maximum dit/dah elements per character.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sym_valid  input  1  ditDah_in carries a symbol this cycle.
REQ-005 ditDah_in  input  2  symbol code: 2'b00 dit, 2'b11 dah, 2'b01 letter gap, 2'b10 word gap.
REQ-006 char_out  output  8  decoded ASCII character, registered.
REQ-007 char_valid  output  1  one-cycle strobe; char_out is valid in that cycle.
REQ-008 char_err  output  1  qualifies char_valid; 1 = undecodable character (char_out = 8'h3F '?').
REQ-009 busy  output  1  high while elements are pending (COLLECT) or a space is queued (EMIT_SPACE).

Function
REQ-010 States: IDLE (no pending elements), COLLECT (1..MAX_ELEM elements held), EMIT_SPACE (space queued behind a flushed letter).
REQ-011 Symbols are accepted only when sym_valid=1; when sym_valid=0, state, element buffer and count hold.
REQ-012 In IDLE, dit or dah stores the element, sets count=1 and moves to COLLECT.
REQ-013 In COLLECT, dit or dah appends the element in arrival order and increments count.
REQ-014 An element arriving when count=MAX_ELEM sets a sticky overflow flag; count saturates at MAX_ELEM.
REQ-015 Letter gap in COLLECT: decode the held pattern, pulse char_valid on the next edge, clear buffer/count/overflow, go to IDLE.
REQ-016 Decode uses standard ITU Morse for A-Z (uppercase ASCII 8'h41-8'h5A) and 0-9 (8'h30-8'h39).
REQ-017 A pattern not in the table, or any pattern with overflow set, yields char_out=8'h3F, char_err=1.
REQ-018 Word gap in COLLECT: emit the decoded letter as in REQ-015, then enter EMIT_SPACE; the next cycle emits 8'h20 with char_err=0 and returns to IDLE.
REQ-019 Word gap in IDLE: emit 8'h20 on the next edge only if the last emitted character was not 8'h20; otherwise no output.
REQ-020 Letter gap in IDLE produces no output and no state change.
REQ-021 In EMIT_SPACE, ditDah_in is ignored for that one cycle, regardless of sym_valid; no symbol is lost if the upstream holds sym_valid=0 for that cycle, and upstream must not issue a symbol in it.
REQ-022 Codes 2'b01/2'b10 count as gaps only; they never become elements.
REQ-023 Latency: char_valid rises exactly one clock after the gap symbol is sampled. The queued space follows one clock later.
REQ-024 char_valid is high for exactly one cycle per character. char_out and char_err hold their last values while char_valid=0.
REQ-025 busy = 1 in COLLECT and EMIT_SPACE; 0 in IDLE.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE and clears count, buffer and overflow; char_out=8'h00, char_valid=0, char_err=0, busy=0.
REQ-027 Reset initialises the last-emitted-space flag to 1, so leading word gaps after reset emit nothing.
REQ-028 Reset asserted mid-character discards pending elements and any queued space; no char_valid is produced.
REQ-029 Outputs are sampled valid from the first rising edge after rst_n deasserts.

Verification
REQ-030 dit, dah, letter gap (sym_valid=1 each cycle) -> char_valid one cycle after the gap, char_out=8'h41 'A', char_err=0.
REQ-031 dah,dah,dah,dah,dah, word gap -> 8'h30 '0', then 8'h20 on the following cycle; busy falls after the space.
REQ-032 Six dits, letter gap -> char_out=8'h3F, char_err=1.
REQ-033 dit,dah,dah,dah,dah,dah... unmapped pattern dah,dah,dit,dit,dah then letter gap -> 8'h3F, char_err=1.
REQ-034 After reset: word gap, word gap -> no char_valid. Then 'E' (dit, letter gap), word gap, word gap -> 8'h45, then a single 8'h20.
REQ-035 dit, dah, then rst_n low one cycle, then letter gap -> no char_valid, busy=0; sym_valid low between symbols leaves the decode unchanged.

Source files
------------

// File: rtl/morse_rx_if.sv
// Symbol-in / character-out bundle for the Morse receiver.
// The master side drives symbols and observes decoded characters.
// The slave side is the receiver itself.
interface morse_rx_if;
   logic       sym_valid;
   logic [1:0] ditDah_in;
   logic [7:0] char_out;
   logic       char_valid;
   logic       char_err;
   logic       busy;

   modport master (
      output sym_valid,
      output ditDah_in,
      input  char_out,
      input  char_valid,
      input  char_err,
      input  busy
   );

   modport slave (
      input  sym_valid,
      input  ditDah_in,
      output char_out,
      output char_valid,
      output char_err,
      output busy
   );
endinterface

// File: rtl/morse_rx.sv
// Morse symbol receiver: collects dit/dah elements, decodes them to ASCII on
// a letter or word gap, and emits a single space after words.
// Element encoding inside the pattern register: dit = 0, dah = 1.
// The oldest element sits at bit (count-1), the newest at bit 0.
module morse_rx #(
   parameter int MAX_ELEM = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   morse_rx_if.slave  bus
);

   // The table covers patterns up to five elements, so the pattern register
   // is never narrower than that even for a small MAX_ELEM.
   localparam int PAT_W = (MAX_ELEM > 5) ? MAX_ELEM : 5;
   localparam int CNT_W = $clog2(MAX_ELEM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ELEM);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [1:0] SYM_LETTER_GAP = 2'b01;
   localparam logic [1:0] SYM_WORD_GAP   = 2'b10;
   localparam logic [7:0] ASCII_SPACE    = 8'h20;
   localparam logic [7:0] ASCII_QMARK    = 8'h3F;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_COLLECT    = 2'b01,
      ST_EMIT_SPACE = 2'b10
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [PAT_W-1:0]   r_pat;
   logic               r_ovf;
   logic               r_last_space;
   logic [7:0]         r_char_out;
   logic               r_char_valid;
   logic               r_char_err;
   logic               r_busy;

   logic               w_is_elem;
   logic               w_elem_bit;
   logic [8:0]         w_decoded;

   // Map a held pattern to {err, ascii}; anything not in the ITU table,
   // longer than five elements, empty, or overflowed becomes an error '?'.
   function automatic logic [8:0] decode_pattern(
      input logic [CNT_W-1:0] len,
      input logic [PAT_W-1:0] pat,
      input logic             ovf
   );
      logic [7:0] key;
      logic [8:0] res;
      res = {1'b1, ASCII_QMARK};
      key = {3'(len), pat[4:0]};
      if (ovf || (int'(len) > 5) || (int'(len) == 0)) begin
         res = {1'b1, ASCII_QMARK};
      end else begin
         case (key)
            8'b001_00000: res = {1'b0, 8'h45}; // E .
            8'b001_00001: res = {1'b0, 8'h54}; // T -
            8'b010_00001: res = {1'b0, 8'h41}; // A .-
            8'b010_00000: res = {1'b0, 8'h49}; // I ..
            8'b010_00011: res = {1'b0, 8'h4D}; // M --
            8'b010_00010: res = {1'b0, 8'h4E}; // N -.
            8'b011_00100: res = {1'b0, 8'h44}; // D -..
            8'b011_00110: res = {1'b0, 8'h47}; // G --.
            8'b011_00101: res = {1'b0, 8'h4B}; // K -.-
            8'b011_00111: res = {1'b0, 8'h4F}; // O ---
            8'b011_00010: res = {1'b0, 8'h52}; // R .-.
            8'b011_00000: res = {1'b0, 8'h53}; // S ...
            8'b011_00001: res = {1'b0, 8'h55}; // U ..-
            8'b011_00011: res = {1'b0, 8'h57}; // W .--
            8'b100_01000: res = {1'b0, 8'h42}; // B -...
            8'b100_01010: res = {1'b0, 8'h43}; // C -.-.
            8'b100_00010: res = {1'b0, 8'h46}; // F ..-.
            8'b100_00000: res = {1'b0, 8'h48}; // H ....
            8'b100_00111: res = {1'b0, 8'h4A}; // J .---
            8'b100_00100: res = {1'b0, 8'h4C}; // L .-..
            8'b100_00110: res = {1'b0, 8'h50}; // P .--.
            8'b100_01101: res = {1'b0, 8'h51}; // Q --.-
            8'b100_00001: res = {1'b0, 8'h56}; // V ...-
            8'b100_01001: res = {1'b0, 8'h58}; // X -..-
            8'b100_01011: res = {1'b0, 8'h59}; // Y -.--
            8'b100_01100: res = {1'b0, 8'h5A}; // Z --..
            8'b101_11111: res = {1'b0, 8'h30}; // 0 -----
            8'b101_01111: res = {1'b0, 8'h31}; // 1 .----
            8'b101_00111: res = {1'b0, 8'h32}; // 2 ..---
            8'b101_00011: res = {1'b0, 8'h33}; // 3 ...--
            8'b101_00001: res = {1'b0, 8'h34}; // 4 ....-
            8'b101_00000: res = {1'b0, 8'h35}; // 5 .....
            8'b101_10000: res = {1'b0, 8'h36}; // 6 -....
            8'b101_11000: res = {1'b0, 8'h37}; // 7 --...
            8'b101_11100: res = {1'b0, 8'h38}; // 8 ---..
            8'b101_11110: res = {1'b0, 8'h39}; // 9 ----.
            default:      res = {1'b1, ASCII_QMARK};
         endcase
      end
      return res;
   endfunction

   // 2'b00 and 2'b11 are the only element codes; dah is the set bit.
   assign w_is_elem  = (bus.ditDah_in[1] == bus.ditDah_in[0]);
   assign w_elem_bit = bus.ditDah_in[1];
   assign w_decoded  = decode_pattern(r_cnt, r_pat, r_ovf);

   assign bus.char_out   = r_char_out;
   assign bus.char_valid = r_char_valid;
   assign bus.char_err   = r_char_err;
   assign bus.busy       = r_busy;

   // Receiver FSM: element collection, decode on gaps, queued space emission.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_pat        <= '0;
         r_ovf        <= 1'b0;
         r_last_space <= 1'b1;
         r_char_out   <= 8'h00;
         r_char_valid <= 1'b0;
         r_char_err   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_char_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.sym_valid) begin
                  if (w_is_elem) begin
                     r_pat   <= {{(PAT_W-1){1'b0}}, w_elem_bit};
                     r_cnt   <= CNT_ONE;
                     r_ovf   <= 1'b0;
                     r_state <= ST_COLLECT;
                     r_busy  <= 1'b1;
                  end else if (bus.ditDah_in == SYM_WORD_GAP) begin
                     // Suppress repeated spaces between words.
                     if (!r_last_space) begin
                        r_char_out   <= ASCII_SPACE;
                        r_char_err   <= 1'b0;
                        r_char_valid <= 1'b1;
                        r_last_space <= 1'b1;
                     end else begin
                        r_last_space <= r_last_space;
                     end
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_COLLECT: begin
               if (bus.sym_valid) begin
                  if (w_is_elem) begin
                     if (r_cnt == CNT_MAX) begin
                        r_ovf <= 1'b1;
                     end else begin
                        r_pat <= {r_pat[PAT_W-2:0], w_elem_bit};
                        r_cnt <= r_cnt + CNT_ONE;
                     end
                  end else begin
                     // Either gap flushes the held letter.
                     r_char_out   <= w_decoded[7:0];
                     r_char_err   <= w_decoded[8];
                     r_char_valid <= 1'b1;
                     r_last_space <= 1'b0;
                     r_pat        <= '0;
                     r_cnt        <= '0;
                     r_ovf        <= 1'b0;
                     if (bus.ditDah_in == SYM_LETTER_GAP) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= ST_EMIT_SPACE;
                        r_busy  <= 1'b1;
                     end
                  end
               end else begin
                  r_state <= ST_COLLECT;
               end
            end

            ST_EMIT_SPACE: begin
               // Input is ignored for this one cycle.
               r_char_out   <= ASCII_SPACE;
               r_char_err   <= 1'b0;
               r_char_valid <= 1'b1;
               r_last_space <= 1'b1;
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
            end

            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_pat   <= '0;
               r_ovf   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_rx.sv
// Self-checking bench for morse_rx: directed scenarios plus randomized
// symbol streams compared cycle by cycle against a string-based model.
module tb_morse_rx;

   localparam int MAX_ELEM = 5;

   logic clk;
   logic rst_n;

   morse_rx_if bus ();

   morse_rx #(.MAX_ELEM(MAX_ELEM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model state: pending elements as a dot/dash string.
   logic [7:0] tbl [string];
   string      mc_code [36];
   string      m_pend;
   bit         m_space_q;
   bit         m_last_sp;
   logic       exp_valid;
   logic       exp_busy;
   logic [7:0] exp_char;
   logic       exp_err;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic build_table();
      string alph;
      alph = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
      mc_code = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                  ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                  "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                  "-----", ".----", "..---", "...--", "....-", ".....",
                  "-....", "--...", "---..", "----."};
      for (int i = 0; i < 36; i++) tbl[mc_code[i]] = alph[i];
   endtask

   task automatic model_reset();
      m_pend    = "";
      m_space_q = 1'b0;
      m_last_sp = 1'b1;
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      exp_char  = 8'h00;
      exp_err   = 1'b0;
   endtask

   task automatic model_emit(input logic [7:0] c, input logic e);
      exp_valid = 1'b1;
      exp_char  = c;
      exp_err   = e;
      m_last_sp = (c == 8'h20);
   endtask

   task automatic model_flush_letter();
      if (m_pend.len() > MAX_ELEM || !tbl.exists(m_pend)) model_emit(8'h3F, 1'b1);
      else model_emit(tbl[m_pend], 1'b0);
      m_pend = "";
   endtask

   // Expected outputs after one clock edge with the given input.
   task automatic model_step(input logic sv, input logic [1:0] code);
      exp_valid = 1'b0;
      if (m_space_q) begin
         model_emit(8'h20, 1'b0);
         m_space_q = 1'b0;
      end else if (sv) begin
         if (code == 2'b00) m_pend = {m_pend, "."};
         else if (code == 2'b11) m_pend = {m_pend, "-"};
         else if (m_pend.len() > 0) begin
            model_flush_letter();
            if (code == 2'b10) m_space_q = 1'b1;
         end else if (code == 2'b10 && !m_last_sp) begin
            model_emit(8'h20, 1'b0);
         end
      end
      exp_busy = (m_pend.len() > 0) || m_space_q;
   endtask

   task automatic compare_outputs(input string where);
      chk_val({where, ".char_valid"}, 32'(bus.char_valid), 32'(exp_valid));
      chk_val({where, ".busy"},       32'(bus.busy),       32'(exp_busy));
      chk_val({where, ".char_out"},   32'(bus.char_out),   32'(exp_char));
      chk_val({where, ".char_err"},   32'(bus.char_err),   32'(exp_err));
   endtask

   task automatic apply(input logic sv, input logic [1:0] code);
      @(negedge clk);
      bus.sym_valid = sv;
      bus.ditDah_in = code;
      @(posedge clk);
      #1;
      model_step(sv, code);
      compare_outputs("step");
   endtask

   // Symbol sender that respects the no-symbol-during-space rule.
   task automatic send(input logic [1:0] code);
      if (m_space_q) apply(1'b0, 2'($urandom_range(3)));
      apply(1'b1, code);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.sym_valid = 1'b0;
      #1;
      model_reset();
      compare_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_string(input string s);
      for (int k = 0; k < s.len(); k++) begin
         send((s[k] == "-") ? 2'b11 : 2'b00);
         if ($urandom_range(3) == 0) apply(1'b0, 2'($urandom_range(3)));
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      build_table();
      model_reset();
      rst_n = 1'b0;
      bus.sym_valid = 1'b0;
      bus.ditDah_in = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      compare_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      // dit dah letter-gap -> 'A'
      send(2'b00); send(2'b11); send(2'b01);
      // five dahs, word gap -> '0' then space
      for (int i = 0; i < 5; i++) send(2'b11);
      send(2'b10);
      apply(1'b0, 2'b00);
      apply(1'b0, 2'b00);
      // six dits -> overflow '?'
      for (int i = 0; i < 6; i++) send(2'b00);
      send(2'b01);
      // unmapped --..- -> '?'
      send(2'b11); send(2'b11); send(2'b00); send(2'b00); send(2'b11); send(2'b01);
      // leading word gaps after reset are silent, then 'E' and one space
      pulse_reset();
      send(2'b10); send(2'b10);
      send(2'b00); send(2'b01);
      send(2'b10); send(2'b10);
      apply(1'b0, 2'b00);
      // reset mid-character discards it; idle cycles between symbols
      send(2'b00);
      apply(1'b0, 2'b11);
      send(2'b11);
      pulse_reset();
      send(2'b01);
      apply(1'b0, 2'b00);
      // letter gap in idle is a no-op
      send(2'b01);

      // Randomized traffic
      for (int it = 0; it < 400; it++) begin
         int mode;
         mode = $urandom_range(99);
         if (mode < 65) begin
            send_string(mc_code[$urandom_range(35)]);
         end else if (mode < 85) begin
            int n;
            string s;
            n = $urandom_range(7);
            s = "";
            for (int k = 0; k < n; k++) s = {s, ($urandom_range(1) != 0) ? "-" : "."};
            send_string(s);
         end else if (mode < 97) begin
            apply(1'b0, 2'($urandom_range(3)));
         end else begin
            pulse_reset();
         end
         send(($urandom_range(2) == 0) ? 2'b10 : 2'b01);
      end
      apply(1'b0, 2'b00);
      apply(1'b0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
